hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline control unit for the in-order five-stage RISC-V core. Generates stall and flush enables for the F/D/E/M/W pipeline registers (including the fetch/decode register's `clr`) and EX-stage forwarding selects. Also sequences a post-reset pipeline purge and freezes the pipe while data memory is busy, flagging wait timeouts.

## Interface
Parameters:
- INIT_CYCLES, 2, cycles of post-reset purge (≥1)
- MAX_WAIT, 16, consecutive data-memory wait cycles before timeout flag (≥2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rs1d, rs2d  in  5  source regs in D
- rs1e, rs2e, rde  in  5  source/dest regs in E
- regwritee, loade  in  1  E writes rd / E is a load
- rdm, rdw  in  5  dest regs in M, W
- regwritem, regwritew  in  1  M, W write rd
- pcsrce  in  1  taken branch/jump resolved in E
- imem_ready  in  1  fetch data valid this cycle
- memaccessm, dmem_ready  in  1  M issues load/store / dmem completes
- stallf, stalld, stalle, stallm  out  1  hold stage register
- flushd, flushe, flushw  out  1  bubble into D, E, W register
- forwardae, forwardbe  out  2  00 regfile, 10 from M, 01 from W
- mem_timeout  out  1  sticky timeout flag
- stall_cnt, flush_cnt  out  32  perf counters (see Configuration)

## Operation
- States: INIT, RUN, DWAIT. Reset → INIT, init_cnt=0, wait_cnt=0, mem_timeout=0, counters 0.
- INIT: stallf=1, flushd=1, flushe=1, flushw=1, all else 0, forward*=00. init_cnt increments each clk; at init_cnt==INIT_CYCLES-1 → RUN.
- dwait = memaccessm & ~dmem_ready. In RUN/DWAIT, dwait has top priority: stallf=stalld=stalle=stallm=1, flushw=1, flushd=flushe=0; pcsrce and lwstall ignored (E frozen, branch resolves after release).
- Else lwstall = loade & regwritee & rde≠0 & (rde==rs1d | rde==rs2d).
- Else pcsrce=1: flushd=1, flushe=1, stallf=0, stalld=0 (PC takes target; overrides lwstall and imem_ready).
- Else lwstall=1: stallf=1, stalld=1, flushe=1.
- Else imem_ready=0: stallf=1, flushd=1.
- Else all 0.
- Forwarding (RUN/DWAIT, independent of stalls): forwardae=10 if regwritem & rdm≠0 & rdm==rs1e; else 01 if regwritew & rdw≠0 & rdw==rs1e; else 00. Same for forwardbe with rs2e. M beats W.
- RUN→DWAIT when dwait, wait_cnt←1. DWAIT: dwait → wait_cnt+1 (saturating at MAX_WAIT); ~dwait → RUN, wait_cnt←0.
- mem_timeout←1 when wait_cnt reaches MAX_WAIT; cleared only by rst.

## Timing
- Stall/flush/forward outputs are combinational from inputs and state; no added latency.
- DWAIT is for counting only; stalls assert on the first dwait cycle while still in RUN.
- INIT lasts exactly INIT_CYCLES rising edges after rst deasserts.
- rst mid-DWAIT or mid-INIT: immediate return to INIT outputs, counts cleared.
- mem_timeout rises on the edge ending the MAX_WAIT-th consecutive wait cycle.

## Configuration
- HAZARD_PERF_EN defined: stall_cnt increments each RUN/DWAIT cycle with stallf=1; flush_cnt increments each cycle flushe=1 due to pcsrce. Both wrap at 2^32, reset to 0, not counted in INIT.
- Undefined: counter registers omitted, stall_cnt=flush_cnt=0 constant.

## Test plan
- Reset, INIT_CYCLES=2 → stallf/flushd/flushe/flushw high for 2 cycles after release, then all 0 with imem_ready=1.
- loade=1, regwritee=1, rde=5, rs1d=5 → stallf=stalld=flushe=1 for one cycle; rde=0 → no stall.
- pcsrce=1 with lwstall and imem_ready=0 → flushd=flushe=1, stallf=0; with HAZARD_PERF_EN flush_cnt=1.
- rdm=rdw=7, both write, rs1e=7 → forwardae=10; regwritem=0 → 01; rdm=rdw=0 → 00.
- memaccessm=1, dmem_ready=0 for 3 cycles, pcsrce=1 → F/D/E/M stall and flushw=1 for 3 cycles, flushe=0; cycle 4 ready → RUN, branch flush.
- dmem_ready=0 held for 16 cycles (MAX_WAIT=16) → mem_timeout=1, stays 1 after ready until rst.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle for hazard_ctrl: register ids and hazard
// inputs in, stall/flush/forward controls and status out.
interface hazard_ctrl_if;
  logic [4:0]  rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  logic        regwritee, loade, regwritem, regwritew;
  logic        pcsrce, imem_ready, memaccessm, dmem_ready;
  logic        stallf, stalld, stalle, stallm;
  logic        flushd, flushe, flushw;
  logic [1:0]  forwardae, forwardbe;
  logic        mem_timeout;
  logic [31:0] stall_cnt, flush_cnt;

  modport master (
    output rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
    output regwritee, loade, regwritem, regwritew,
    output pcsrce, imem_ready, memaccessm, dmem_ready,
    input  stallf, stalld, stalle, stallm, flushd, flushe, flushw,
    input  forwardae, forwardbe, mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
    input  regwritee, loade, regwritem, regwritew,
    input  pcsrce, imem_ready, memaccessm, dmem_ready,
    output stallf, stalld, stalle, stallm, flushd, flushe, flushw,
    output forwardae, forwardbe, mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard unit: stalls, flushes, EX forwarding, reset purge,
// dmem-wait freeze with sticky timeout. Optional perf counters: HAZARD_PERF_EN.
module hazard_ctrl #(
  parameter int INIT_CYCLES = 2,
  parameter int MAX_WAIT    = 16
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);

  localparam int IW = $clog2(INIT_CYCLES + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {INIT, RUN, DWAIT} state_t;

  state_t        state_reg, state_next;
  logic [IW-1:0] init_cnt_reg, init_cnt_next;
  logic [WW-1:0] wait_cnt_reg, wait_cnt_next;
  logic          timeout_reg, timeout_next;

  logic stallf, stalld, stalle, stallm, flushd, flushe, flushw;
  logic [1:0] forwardae, forwardbe;
  logic dwait, lwstall, branch_flush;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic wm, input logic [4:0] rm,
                                         input logic ww, input logic [4:0] rw);
    if (wm && rm != 5'd0 && rm == rs)      return 2'b10;
    else if (ww && rw != 5'd0 && rw == rs) return 2'b01;
    else                                   return 2'b00;
  endfunction

  assign dwait   = hz.memaccessm & ~hz.dmem_ready;
  assign lwstall = hz.loade & hz.regwritee & (hz.rde != 5'd0) &
                   ((hz.rde == hz.rs1d) | (hz.rde == hz.rs2d));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= INIT;
      init_cnt_reg <= '0;
      wait_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      init_cnt_reg <= init_cnt_next;
      wait_cnt_reg <= wait_cnt_next;
      timeout_reg  <= timeout_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    init_cnt_next = init_cnt_reg;
    wait_cnt_next = wait_cnt_reg;
    stallf = 1'b0; stalld = 1'b0; stalle = 1'b0; stallm = 1'b0;
    flushd = 1'b0; flushe = 1'b0; flushw = 1'b0;
    forwardae    = 2'b00;
    forwardbe    = 2'b00;
    branch_flush = 1'b0;

    case (state_reg)
      INIT: begin
        stallf = 1'b1; flushd = 1'b1; flushe = 1'b1; flushw = 1'b1;
        if (init_cnt_reg == IW'(INIT_CYCLES - 1)) state_next = RUN;
        else                                      init_cnt_next = init_cnt_reg + 1'b1;
      end
      default: begin
        forwardae = fwd_sel(hz.rs1e, hz.regwritem, hz.rdm, hz.regwritew, hz.rdw);
        forwardbe = fwd_sel(hz.rs2e, hz.regwritem, hz.rdm, hz.regwritew, hz.rdw);
        // A memory wait freezes everything; the branch in E resolves after release.
        if (dwait) begin
          stallf = 1'b1; stalld = 1'b1; stalle = 1'b1; stallm = 1'b1;
          flushw = 1'b1;
        end else if (hz.pcsrce) begin
          flushd = 1'b1; flushe = 1'b1;
          branch_flush = 1'b1;
        end else if (lwstall) begin
          stallf = 1'b1; stalld = 1'b1; flushe = 1'b1;
        end else if (!hz.imem_ready) begin
          stallf = 1'b1; flushd = 1'b1;
        end

        if (dwait) begin
          state_next = DWAIT;
          if (state_reg == RUN)                      wait_cnt_next = WW'(1);
          else if (wait_cnt_reg != WW'(MAX_WAIT))    wait_cnt_next = wait_cnt_reg + 1'b1;
        end else begin
          state_next    = RUN;
          wait_cnt_next = '0;
        end
      end
    endcase

    timeout_next = timeout_reg | (wait_cnt_next == WW'(MAX_WAIT));
  end

  assign hz.stallf      = stallf;
  assign hz.stalld      = stalld;
  assign hz.stalle      = stalle;
  assign hz.stallm      = stallm;
  assign hz.flushd      = flushd;
  assign hz.flushe      = flushe;
  assign hz.flushw      = flushw;
  assign hz.forwardae   = forwardae;
  assign hz.forwardbe   = forwardbe;
  assign hz.mem_timeout = timeout_reg;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_reg, flush_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else if (state_reg != INIT) begin
      if (stallf)       stall_cnt_reg <= stall_cnt_reg + 32'd1;
      if (branch_flush) flush_cnt_reg <= flush_cnt_reg + 32'd1;
    end
  end

  assign hz.stall_cnt = stall_cnt_reg;
  assign hz.flush_cnt = flush_cnt_reg;
`else
  assign hz.stall_cnt = 32'd0;
  assign hz.flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a cycle-level reference model queues the
// expected outputs for every applied vector; a negedge monitor compares.
module tb_hazard_ctrl;
  localparam int INIT_CYCLES = 2;
  localparam int MAX_WAIT    = 16;

  typedef struct {
    logic       rst;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       regwritee, loade, regwritem, regwritew;
    logic       pcsrce, imem_ready, memaccessm, dmem_ready;
  } stim_t;

  typedef struct {
    logic [6:0]  ctl;   // stallf stalld stalle stallm flushd flushe flushw
    logic [3:0]  fwd;   // forwardae forwardbe
    logic        tmo;
    logic [63:0] perf;  // stall_cnt flush_cnt
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if hz();
  hazard_ctrl #(.INIT_CYCLES(INIT_CYCLES), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .hz(hz)
  );

  exp_t  exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  // reference model state, expressed in terms of elapsed cycles
  stim_t       cur, prev;
  exp_t        last_exp;
  int          cycles_since_reset = 0;
  int          consec_waits = 0;
  bit          timed_out = 0;
  logic [31:0] stall_cycles = 0, branch_flushes = 0;

  function automatic logic [1:0] fwd_of(logic [4:0] rs, stim_t s);
    if (s.regwritem && s.rdm != 0 && s.rdm == rs) return 2'b10;
    if (s.regwritew && s.rdw != 0 && s.rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t expect_of(stim_t s);
    exp_t e;
    bit lw;
    e.ctl = 7'b0; e.fwd = 4'b0;
    lw = s.loade && s.regwritee && s.rde != 0 && (s.rde == s.rs1d || s.rde == s.rs2d);
    if (cycles_since_reset < INIT_CYCLES)        e.ctl = 7'b1000111;
    else begin
      e.fwd = {fwd_of(s.rs1e, s), fwd_of(s.rs2e, s)};
      if (s.memaccessm && !s.dmem_ready)         e.ctl = 7'b1111001;
      else if (s.pcsrce)                         e.ctl = 7'b0000110;
      else if (lw)                               e.ctl = 7'b1100010;
      else if (!s.imem_ready)                    e.ctl = 7'b1000100;
    end
    e.tmo = timed_out;
`ifdef HAZARD_PERF_EN
    e.perf = {stall_cycles, branch_flushes};
`else
    e.perf = 64'd0;
`endif
    return e;
  endfunction

  task automatic model_reset();
    cycles_since_reset = 0; consec_waits = 0; timed_out = 0;
    stall_cycles = 0; branch_flushes = 0;
  endtask

  task automatic step();
    bit w;
    @(posedge clk);
    if (prev.rst) model_reset();
    else if (cycles_since_reset < INIT_CYCLES) cycles_since_reset++;
    else begin
      w = prev.memaccessm && !prev.dmem_ready;
      consec_waits = w ? ((consec_waits < MAX_WAIT) ? consec_waits + 1 : MAX_WAIT) : 0;
      if (consec_waits == MAX_WAIT) timed_out = 1;
      if (last_exp.ctl[6]) stall_cycles++;
      if (!w && prev.pcsrce) branch_flushes++;
    end
    #1;
    rst = cur.rst;
    hz.rs1d = cur.rs1d; hz.rs2d = cur.rs2d; hz.rs1e = cur.rs1e; hz.rs2e = cur.rs2e;
    hz.rde = cur.rde; hz.rdm = cur.rdm; hz.rdw = cur.rdw;
    hz.regwritee = cur.regwritee; hz.loade = cur.loade;
    hz.regwritem = cur.regwritem; hz.regwritew = cur.regwritew;
    hz.pcsrce = cur.pcsrce; hz.imem_ready = cur.imem_ready;
    hz.memaccessm = cur.memaccessm; hz.dmem_ready = cur.dmem_ready;
    prev = cur;
    if (cur.rst) model_reset();
    last_exp = expect_of(cur);
    exp_q.push_back(last_exp);
  endtask

  task automatic idle_stim();
    cur = '{rst: 1'b0, rs1d: 5'd0, rs2d: 5'd0, rs1e: 5'd0, rs2e: 5'd0, rde: 5'd0,
            rdm: 5'd0, rdw: 5'd0, regwritee: 1'b0, loade: 1'b0, regwritem: 1'b0,
            regwritew: 1'b0, pcsrce: 1'b0, imem_ready: 1'b1, memaccessm: 1'b0,
            dmem_ready: 1'b1};
  endtask

  task automatic rand_stim();
    cur.rst = 1'b0;
    cur.rs1d = 5'($urandom_range(0, 3)); cur.rs2d = 5'($urandom_range(0, 3));
    cur.rs1e = 5'($urandom_range(0, 3)); cur.rs2e = 5'($urandom_range(0, 3));
    cur.rde  = 5'($urandom_range(0, 3)); cur.rdm  = 5'($urandom_range(0, 3));
    cur.rdw  = 5'($urandom_range(0, 3));
    cur.regwritee = 1'($urandom_range(0, 1)); cur.loade = 1'($urandom_range(0, 1));
    cur.regwritem = 1'($urandom_range(0, 1)); cur.regwritew = 1'($urandom_range(0, 1));
    cur.pcsrce     = ($urandom_range(0, 5) == 0);
    cur.imem_ready = ($urandom_range(0, 4) != 0);
    cur.memaccessm = ($urandom_range(0, 3) == 0);
    cur.dmem_ready = ($urandom_range(0, 3) != 0);
  endtask

  // monitor: one comparison group per output class, every cycle a vector is queued
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        vectors++;
        if ({hz.stallf, hz.stalld, hz.stalle, hz.stallm, hz.flushd, hz.flushe, hz.flushw} !== e.ctl) begin
          miscompares++;
          $display("FAIL ctl vec %0d got %b want %b", vectors,
                   {hz.stallf, hz.stalld, hz.stalle, hz.stallm, hz.flushd, hz.flushe, hz.flushw}, e.ctl);
        end
        if ({hz.forwardae, hz.forwardbe} !== e.fwd) begin
          miscompares++;
          $display("FAIL fwd vec %0d got %b want %b", vectors, {hz.forwardae, hz.forwardbe}, e.fwd);
        end
        if (hz.mem_timeout !== e.tmo) begin
          miscompares++;
          $display("FAIL mem_timeout vec %0d got %b want %b", vectors, hz.mem_timeout, e.tmo);
        end
        if ({hz.stall_cnt, hz.flush_cnt} !== e.perf) begin
          miscompares++;
          $display("FAIL perf vec %0d got %h want %h", vectors, {hz.stall_cnt, hz.flush_cnt}, e.perf);
        end
        $display("vec %0d ctl=%b fwd=%b tmo=%b", vectors, e.ctl, e.fwd, e.tmo);
      end
    end
  end

  initial begin
    idle_stim(); cur.rst = 1'b1; prev = cur;
    last_exp = '{ctl: 7'b0, fwd: 4'b0, tmo: 1'b0, perf: 64'd0};
    step(); step();
    idle_stim();
    repeat (4) step();                       // purge, then quiet RUN

    cur.loade = 1; cur.regwritee = 1; cur.rde = 5; cur.rs1d = 5; step();
    cur.rde = 0; step();
    cur.rde = 5; cur.pcsrce = 1; cur.imem_ready = 0; step();
    idle_stim();

    cur.rdm = 7; cur.rdw = 7; cur.regwritem = 1; cur.regwritew = 1; cur.rs1e = 7; cur.rs2e = 7; step();
    cur.regwritem = 0; step();
    cur.rdm = 0; cur.rdw = 0; cur.regwritem = 1; step();
    idle_stim();

    cur.memaccessm = 1; cur.dmem_ready = 0; cur.pcsrce = 1;
    repeat (3) step();
    cur.dmem_ready = 1; step();
    idle_stim(); step();

    repeat (400) begin rand_stim(); step(); end

    idle_stim(); cur.memaccessm = 1; cur.dmem_ready = 0;
    repeat (MAX_WAIT + 2) step();            // timeout, then saturated wait
    repeat (6) begin rand_stim(); cur.memaccessm = 0; step(); end

    idle_stim(); cur.memaccessm = 1; cur.dmem_ready = 0;
    repeat (3) step();
    cur.rst = 1; step();                     // reset in the middle of a wait
    cur.rst = 0; step();
    cur.rst = 1; step();                     // reset in the middle of the purge
    idle_stim();
    repeat (200) begin rand_stim(); step(); end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    @(posedge clk); #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
